// File: rtl/pwm_multi_ch_if.sv
// pwm_multi_ch_if
//   Control and status bundle between the fan control FSM and the PWM block.
//   master : fan control side. Drives the timebase settings, duty values,
//            write strobes and enables, and observes the outputs.
//   slave  : PWM generator side.
//
//   step_div     clk cycles per counter step (0 and 1 both mean every clk)
//   center_mode  0 = edge-aligned, 1 = center-aligned (taken at boundary)
//   duty         packed duty values, channel i at [i*(RES_BITS+1) +: RES_BITS+1]
//   duty_we      per-channel shadow write strobe
//   enable       per-channel enable
//   pwm_out      registered PWM outputs
//   period_start one-clk pulse when the counter returns to 0
interface pwm_multi_ch_if #(
  parameter int CH       = 4,
  parameter int RES_BITS = 8,
  parameter int DIV_W    = 24
);
  logic [DIV_W-1:0]           step_div;
  logic                       center_mode;
  logic [CH*(RES_BITS+1)-1:0] duty;
  logic [CH-1:0]              duty_we;
  logic [CH-1:0]              enable;
  logic [CH-1:0]              pwm_out;
  logic                       period_start;

  modport master (
    output step_div, center_mode, duty, duty_we, enable,
    input  pwm_out, period_start
  );

  modport slave (
    input  step_div, center_mode, duty, duty_we, enable,
    output pwm_out, period_start
  );
endinterface

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch
//   Multi-channel PWM generator with one shared timebase. A prescaler turns
//   clk into counter steps. The counter runs either edge-aligned
//   (0..MAX, wrap) or center-aligned (0..MAX..1, then 0). Each channel has a
//   shadow duty register that is copied into its active register at the
//   period boundary, which keeps the outputs free of glitches.
//
//   Ports
//     clk      system clock
//     reset_p  asynchronous, active-high reset
//     bus      pwm_multi_ch_if.slave: step_div, center_mode, duty, duty_we,
//              enable in; pwm_out, period_start out
module pwm_multi_ch #(
  parameter int CH       = 4,
  parameter int RES_BITS = 8,
  parameter int DIV_W    = 24
) (
  input logic           clk,
  input logic           reset_p,
  pwm_multi_ch_if.slave bus
);

  localparam int DW = RES_BITS + 1;
  localparam logic [RES_BITS-1:0] MAX = '1;
  localparam logic [RES_BITS-1:0] ONE = RES_BITS'(1);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [DIV_W-1:0]    pre_cnt;
  logic [DIV_W-1:0]    limit;
  logic                tick;
  logic [RES_BITS-1:0] cnt;
  logic [RES_BITS-1:0] cnt_nxt;
  dir_t                dir;
  dir_t                dir_nxt;
  logic                mode_act;
  logic                boundary;
  logic [DW-1:0]       shadow   [CH];
  logic [DW-1:0]       duty_act [CH];
  logic [CH-1:0]       pwm_r;
  logic                period_r;

  // The comparison uses >= so that a step_div which shrinks below the running
  // prescaler count still produces a tick on the next clk.
  assign limit = (bus.step_div == '0) ? '0 : bus.step_div - 1'b1;
  assign tick  = (pre_cnt >= limit);

  // Next counter value and direction. Center mode turns around at MAX and at
  // 0, so MAX and 0 are each visited once per period (2*MAX steps).
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (tick) begin
      if (!mode_act) begin
        cnt_nxt = cnt + 1'b1;
      end else if (dir == DIR_UP) begin
        if (cnt == MAX) begin
          cnt_nxt = cnt - 1'b1;
          dir_nxt = DIR_DOWN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == ONE) begin
          dir_nxt = DIR_UP;
        end
      end
    end
  end

  // The boundary is the tick on which the counter becomes 0.
  assign boundary = tick && (cnt_nxt == '0);

  // Timebase state. The counting mode is latched only at the boundary, so a
  // mid-period center_mode change waits for the next period.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      pre_cnt  <= '0;
      cnt      <= '0;
      dir      <= DIR_UP;
      mode_act <= 1'b0;
      period_r <= 1'b0;
    end else begin
      pre_cnt  <= tick ? '0 : pre_cnt + 1'b1;
      cnt      <= cnt_nxt;
      dir      <= boundary ? DIR_UP : dir_nxt;
      period_r <= boundary;
      if (boundary) begin
        mode_act <= bus.center_mode;
      end
    end
  end

  // Per-channel duty and output registers. A write to a disabled channel
  // goes straight into duty_act because nothing is visible to glitch. If a
  // write coincides with the boundary on an enabled channel, duty_act takes
  // the old shadow value and the new value waits one period.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      for (int i = 0; i < CH; i++) begin
        shadow[i]   <= '0;
        duty_act[i] <= '0;
      end
      pwm_r <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        pwm_r[i] <= bus.enable[i] & ({1'b0, cnt} < duty_act[i]);
        if (bus.duty_we[i] && !bus.enable[i]) begin
          duty_act[i] <= bus.duty[i*DW +: DW];
        end else if (boundary) begin
          duty_act[i] <= shadow[i];
        end
        if (bus.duty_we[i]) begin
          shadow[i] <= bus.duty[i*DW +: DW];
        end
      end
    end
  end

  assign bus.pwm_out      = pwm_r;
  assign bus.period_start = period_r;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch
//   Bench for pwm_multi_ch with CH=2, RES_BITS=4, DIV_W=8. A reference model
//   tracks the step index within the period and derives the counter value
//   arithmetically. Every clk, both outputs are compared against the model.
//   A vector table and a few hand-written sequences check per-period high
//   times, period lengths and the corner cases around shadowing and reset.
module tb_pwm_multi_ch;

  localparam int CH     = 2;
  localparam int RB     = 4;
  localparam int DIVW   = 8;
  localparam int DUTY_W = RB + 1;
  localparam int MAXV   = (1 << RB) - 1;

  typedef struct {
    int         d0;
    int         d1;
    logic [1:0] en;
    int         div;
    bit         ctr;
    int         nper;
    int         per;
    int         hi0;
    int         hi1;
  } vec_t;

  logic clk = 1'b0;
  logic reset_p;

  pwm_multi_ch_if #(.CH(CH), .RES_BITS(RB), .DIV_W(DIVW)) bus ();

  pwm_multi_ch #(.CH(CH), .RES_BITS(RB), .DIV_W(DIVW)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "init";

  int         m_pre;
  int         m_k;
  int         m_mode;
  int         m_shadow [CH];
  int         m_act    [CH];
  logic [1:0] m_pwm;
  logic       m_ps;

  vec_t vecs [8];

  task automatic model_reset();
    m_pre  = 0;
    m_k    = 0;
    m_mode = 0;
    for (int i = 0; i < CH; i++) begin
      m_shadow[i] = 0;
      m_act[i]    = 0;
    end
    m_pwm = '0;
    m_ps  = 1'b0;
  endtask

  // The model keeps the step index k inside the current period. The counter
  // value follows from k: k for edge mode, a triangle for center mode.
  task automatic model_update();
    int         lim;
    int         plen;
    int         c;
    int         d;
    bit         step;
    bit         bnd;
    logic [1:0] pn;
    lim  = (bus.step_div == 0) ? 1 : int'(bus.step_div);
    step = (m_pre + 1 >= lim);
    plen = (m_mode != 0) ? 2 * MAXV : MAXV + 1;
    c    = (m_mode != 0 && m_k > MAXV) ? 2 * MAXV - m_k : m_k;
    for (int i = 0; i < CH; i++) begin
      pn[i] = bus.enable[i] && (c < m_act[i]);
    end
    bnd   = step && (m_k + 1 == plen);
    m_pre = step ? 0 : m_pre + 1;
    if (step) begin
      m_k = bnd ? 0 : m_k + 1;
    end
    for (int i = 0; i < CH; i++) begin
      d = int'(bus.duty[i*DUTY_W +: DUTY_W]);
      if (bus.duty_we[i] && !bus.enable[i]) begin
        m_act[i] = d;
      end else if (bnd) begin
        m_act[i] = m_shadow[i];
      end
      if (bus.duty_we[i]) begin
        m_shadow[i] = d;
      end
    end
    if (bnd) begin
      m_mode = bus.center_mode ? 1 : 0;
    end
    m_pwm = pn;
    m_ps  = bnd;
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_output();
    n_tests++;
    if (bus.pwm_out !== m_pwm) begin
      n_fail++;
      $display("[TB] FAIL %s pwm_out: got %b, expected %b at %0t", phase, bus.pwm_out, m_pwm, $time);
    end
    n_tests++;
    if (bus.period_start !== m_ps) begin
      n_fail++;
      $display("[TB] FAIL %s period_start: got %b, expected %b at %0t", phase, bus.period_start, m_ps, $time);
    end
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    if (reset_p) model_reset();
    else model_update();
    #1;
    check_output();
  endtask

  task automatic set_duty(input int ch, input int v);
    logic [DUTY_W-1:0] vv;
    vv = DUTY_W'(v);
    bus.duty[ch*DUTY_W +: DUTY_W] = vv;
  endtask

  // Resets the DUT, programs both duties through a write while disabled,
  // then applies the requested enables.
  task automatic apply_stimulus(input int d0, input int d1, input logic [1:0] en,
                                input int div, input bit ctr);
    reset_p         = 1'b1;
    bus.step_div    = DIVW'(div);
    bus.center_mode = ctr;
    bus.duty_we     = '0;
    bus.enable      = '0;
    set_duty(0, d0);
    set_duty(1, d1);
    model_reset();
    clk_cycle();
    clk_cycle();
    reset_p     = 1'b0;
    bus.duty_we = 2'b11;
    clk_cycle();
    bus.duty_we = '0;
    bus.enable  = en;
  endtask

  task automatic wait_ps(input string name);
    int k;
    k = 0;
    while (bus.period_start !== 1'b1 && k < 200) begin
      clk_cycle();
      k++;
    end
    check_int({name, " wait period_start"}, int'(bus.period_start === 1'b1), 1);
  endtask

  task automatic measure(input int n, output int hi0, output int hi1, output int pulses);
    hi0    = 0;
    hi1    = 0;
    pulses = 0;
    for (int e = 0; e < n; e++) begin
      clk_cycle();
      hi0    += int'(bus.pwm_out[0]);
      hi1    += int'(bus.pwm_out[1]);
      pulses += int'(bus.period_start);
    end
  endtask

  // Runs n clks. Before clk number 'at' (1-based), it applies one event:
  // kind 0 writes duty0=val, kind 1 sets center_mode=val, kind 2 sets
  // step_div=val.
  task automatic run_event(input int n, input int at, input int kind, input int val,
                           output int hi0, output int pulses);
    hi0    = 0;
    pulses = 0;
    for (int e = 1; e <= n; e++) begin
      if (e == at) begin
        case (kind)
          0: begin set_duty(0, val); bus.duty_we = 2'b01; end
          1: bus.center_mode = (val != 0);
          default: bus.step_div = DIVW'(val);
        endcase
      end
      clk_cycle();
      bus.duty_we = '0;
      hi0    += int'(bus.pwm_out[0]);
      pulses += int'(bus.period_start);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int h0;
    int h1;
    int p;

    vecs[0] = '{4,  12, 2'b11, 1, 1'b0, 1, 16, 4,  12};
    vecs[1] = '{0,  16, 2'b11, 1, 1'b0, 3, 16, 0,  48};
    vecs[2] = '{4,  9,  2'b11, 1, 1'b1, 1, 30, 7,  17};
    vecs[3] = '{5,  16, 2'b11, 3, 1'b0, 1, 48, 15, 48};
    vecs[4] = '{6,  3,  2'b01, 2, 1'b0, 1, 32, 12, 0};
    vecs[5] = '{16, 0,  2'b11, 1, 1'b1, 2, 30, 60, 0};
    vecs[6] = '{7,  8,  2'b11, 1, 1'b1, 1, 30, 13, 15};
    vecs[7] = '{31, 1,  2'b11, 1, 1'b0, 1, 16, 16, 1};

    reset_p         = 1'b1;
    bus.step_div    = '0;
    bus.center_mode = 1'b0;
    bus.duty        = '0;
    bus.duty_we     = '0;
    bus.enable      = '0;
    model_reset();
    #3;
    phase = "reset";
    check_int("reset pwm_out", int'(bus.pwm_out), 0);
    check_int("reset period_start", int'(bus.period_start), 0);

    for (int v = 0; v < 8; v++) begin
      phase = $sformatf("vec%0d", v);
      apply_stimulus(vecs[v].d0, vecs[v].d1, vecs[v].en, vecs[v].div, vecs[v].ctr);
      wait_ps(phase);
      measure(vecs[v].nper * vecs[v].per, h0, h1, p);
      check_int({phase, " hi0"}, h0, vecs[v].hi0);
      check_int({phase, " hi1"}, h1, vecs[v].hi1);
      check_int({phase, " pulses"}, p, vecs[v].nper);
      check_int({phase, " ps at period end"}, int'(bus.period_start), 1);
    end

    phase = "shadow";
    apply_stimulus(4, 0, 2'b01, 1, 1'b0);
    wait_ps(phase);
    run_event(16, 7, 0, 8, h0, p);
    check_int("shadow current period hi0", h0, 4);
    check_int("shadow current period pulses", p, 1);
    measure(16, h0, h1, p);
    check_int("shadow next period hi0", h0, 8);
    run_event(16, 16, 0, 2, h0, p);
    check_int("coincident write period hi0", h0, 8);
    measure(16, h0, h1, p);
    check_int("coincident write deferred hi0", h0, 8);
    measure(16, h0, h1, p);
    check_int("coincident write applied hi0", h0, 2);

    phase = "center_toggle";
    apply_stimulus(4, 0, 2'b01, 1, 1'b1);
    wait_ps(phase);
    run_event(30, 10, 1, 0, h0, p);
    check_int("center toggle same period hi0", h0, 7);
    check_int("center toggle same period pulses", p, 1);
    check_int("center toggle period end", int'(bus.period_start), 1);
    measure(16, h0, h1, p);
    check_int("after toggle edge hi0", h0, 4);
    check_int("after toggle edge pulses", p, 1);

    phase = "div_shrink";
    apply_stimulus(3, 0, 2'b01, 100, 1'b0);
    run_event(59, 50, 2, 2, h0, p);
    check_int("div shrink hi0", h0, 54);
    check_int("div shrink pulses", p, 0);

    phase = "async_reset";
    apply_stimulus(8, 16, 2'b11, 1, 1'b0);
    wait_ps(phase);
    #2;
    reset_p = 1'b1;
    model_reset();
    #1;
    check_int("async reset pwm_out", int'(bus.pwm_out), 0);
    check_int("async reset period_start", int'(bus.period_start), 0);
    clk_cycle();
    clk_cycle();
    reset_p = 1'b0;
    measure(16, h0, h1, p);
    check_int("after reset hi0", h0, 0);
    check_int("after reset hi1", h1, 0);
    check_int("after reset first pulse count", p, 1);
    check_int("after reset first pulse at wrap", int'(bus.period_start), 1);
    bus.enable = 2'b00;
    set_duty(0, 8);
    bus.duty_we = 2'b01;
    clk_cycle();
    bus.duty_we = '0;
    bus.enable  = 2'b01;
    wait_ps(phase);
    measure(16, h0, h1, p);
    check_int("rewrite after reset hi0", h0, 8);

    phase = "random";
    apply_stimulus(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 2'b11, 1, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) bus.step_div = DIVW'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) bus.center_mode = ~bus.center_mode;
      if ($urandom_range(0, 29) == 0) bus.enable = 2'($urandom_range(0, 3));
      bus.duty    = 10'($urandom);
      bus.duty_we = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      clk_cycle();
    end
    bus.duty_we = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
